livello_logger: RTL and testbench

- Sits directly downstream of the level counter.
- Consumes the counter's `livello` value and `enram` write strobe, and logs each accepted level into a circular history buffer of DEPTH entries.
- Provides indexed read-back of that history.
- Runs a threshold FSM that pulses `clear` back to the level counter and raises a latched `alarm` when a logged level reaches SOGLIA.

---
 rtl/livello_logger.sv | 132 +++++++++++++
 tb/tb_livello_logger.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/livello_logger.sv
// Level history logger: circular buffer of accepted levels with indexed read-back,
// peak tracking and a threshold FSM that clears the upstream counter and latches an alarm.
module livello_logger #(
    parameter int MAXB   = 9,
    parameter int DEPTH  = 8,
    parameter int AW     = 3,
    parameter int SOGLIA = 300
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sw,
    input  logic            enram,
    input  logic [MAXB-1:0] livello,
    input  logic            rd_req,
    input  logic [AW-1:0]   rd_idx,
    output logic [MAXB-1:0] rd_data,
    output logic            rd_valid,
    output logic [AW:0]     count,
    output logic            full,
    output logic [MAXB-1:0] peak,
    output logic            clear,
    output logic            alarm,
    input  logic            ack
);

    localparam logic [1:0]      S_IDLE   = 2'd0;
    localparam logic [1:0]      S_FIRE   = 2'd1;
    localparam logic [1:0]      S_ALARM  = 2'd2;
    localparam logic [AW:0]     CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [MAXB-1:0] THR      = MAXB'(SOGLIA);

    logic [MAXB-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW:0]     r_count;
    logic [MAXB-1:0] r_peak;
    logic [MAXB-1:0] r_rd_data;
    logic            r_rd_valid;
    logic [1:0]      r_state;
    logic            r_clear;
    logic            r_alarm;

    logic            w_flush;
    logic            w_wr;
    logic            w_rd;
    logic [AW-1:0]   w_rd_addr;
    logic            w_rd_hit;
    logic [1:0]      w_state_nxt;

    assign w_flush = rst | ~sw;
    assign w_wr    = enram & sw & ~rst;
    assign w_rd    = rd_req & sw;

    // Age index to physical slot, relative to the pre-write pointer
    always_comb begin
        w_rd_addr = r_wptr - AW'(1) - rd_idx;
        w_rd_hit  = ({1'b0, rd_idx} < r_count);
    end

    // Threshold FSM next-state; only IDLE can fire, so writes during FIRE/ALARM never re-trigger
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_wr && (livello >= THR)) begin
                    w_state_nxt = S_FIRE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FIRE: begin
                w_state_nxt = S_ALARM;
            end
            S_ALARM: begin
                if (ack) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_ALARM;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // History storage; contents are left unreset since count gates visibility
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= livello;
        end
    end

    // Control state: pointer, occupancy, peak, read port and FSM outputs
    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_wptr     <= '0;
            r_count    <= '0;
            r_peak     <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_state    <= S_IDLE;
            r_clear    <= 1'b0;
            r_alarm    <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
                if (r_count != CNT_FULL) begin
                    r_count <= r_count + (AW+1)'(1);
                end
                if (livello > r_peak) begin
                    r_peak <= livello;
                end
            end
            r_rd_valid <= w_rd;
            if (w_rd) begin
                r_rd_data <= w_rd_hit ? r_mem[w_rd_addr] : '0;
            end
            r_state <= w_state_nxt;
            r_clear <= (w_state_nxt == S_FIRE);
            r_alarm <= (w_state_nxt != S_IDLE);
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign count    = r_count;
    assign full     = (r_count == CNT_FULL);
    assign peak     = r_peak;
    assign clear    = r_clear;
    assign alarm    = r_alarm;

endmodule

// File: tb/tb_livello_logger.sv
// Directed, table-driven bench for livello_logger (DEPTH=8, SOGLIA=300).
module tb_livello_logger;

    logic       clk = 1'b0;
    logic       rst, sw, enram, rd_req, ack;
    logic [8:0] livello;
    logic [2:0] rd_idx;
    logic [8:0] rd_data, peak;
    logic       rd_valid, full, clear, alarm;
    logic [3:0] count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int rst, sw, en, liv, rq, idx, ack;
        int v, d, c, f, p, cl, al;
    } vec_t;

    vec_t tbl[$];

    livello_logger #(.MAXB(9), .DEPTH(8), .AW(3), .SOGLIA(300)) dut (
        .clk(clk), .rst(rst), .sw(sw), .enram(enram), .livello(livello),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid),
        .count(count), .full(full), .peak(peak), .clear(clear), .alarm(alarm),
        .ack(ack)
    );

    always #5 clk = ~clk;

    task automatic add(input int rst_i, input int sw_i, input int en_i, input int liv_i,
                       input int rq_i, input int idx_i, input int ack_i,
                       input int v_e, input int d_e, input int c_e, input int f_e,
                       input int p_e, input int cl_e, input int al_e);
        vec_t r;
        r.rst = rst_i; r.sw = sw_i; r.en = en_i; r.liv = liv_i;
        r.rq = rq_i; r.idx = idx_i; r.ack = ack_i;
        r.v = v_e; r.d = d_e; r.c = c_e; r.f = f_e; r.p = p_e; r.cl = cl_e; r.al = al_e;
        tbl.push_back(r);
    endtask

    task automatic chk(input string name, input int row, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, row, act, exp);
        end
    endtask

    task automatic drive(input int r, input int s, input int e, input int l,
                         input int q, input int i, input int a);
        @(negedge clk);
        rst = r[0]; sw = s[0]; enram = e[0]; livello = 9'(l);
        rd_req = q[0]; rd_idx = 3'(i); ack = a[0];
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; sw = 1'b0; enram = 1'b0; livello = 9'd0;
        rd_req = 1'b0; rd_idx = 3'd0; ack = 1'b0;

        // rst sw en liv rq idx ack | valid data count full peak clear alarm
        add(1,0,0,0,0,0,0, 0,0,0,0,0,0,0);
        add(0,1,0,0,0,0,0, 0,0,0,0,0,0,0);
        add(0,1,1,5,0,0,0, 0,0,1,0,5,0,0);
        add(0,1,1,10,0,0,0, 0,0,2,0,10,0,0);
        add(0,1,1,15,0,0,0, 0,0,3,0,15,0,0);
        add(0,1,0,0,1,3,0, 1,0,3,0,15,0,0);
        add(0,1,0,0,1,0,0, 1,15,3,0,15,0,0);
        add(0,1,0,0,1,2,0, 1,5,3,0,15,0,0);
        add(0,1,0,0,0,0,0, 0,5,3,0,15,0,0);
        add(0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
        for (int i = 0; i < 10; i++)
            add(0,1,1,5*(i+1),0,0,0, 0,0,(i+1 > 8) ? 8 : i+1,(i >= 7) ? 1 : 0,5*(i+1),0,0);
        add(0,1,0,0,1,0,0, 1,50,8,1,50,0,0);
        add(0,1,0,0,1,7,0, 1,15,8,1,50,0,0);
        add(0,1,0,0,1,1,0, 1,45,8,1,50,0,0);
        add(0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
        add(0,1,1,5,0,0,0, 0,0,1,0,5,0,0);
        add(0,1,1,10,0,0,0, 0,0,2,0,10,0,0);
        add(0,1,1,15,1,0,0, 1,10,3,0,15,0,0);
        add(0,1,0,0,1,0,0, 1,15,3,0,15,0,0);
        add(0,1,1,295,0,0,0, 0,15,4,0,295,0,0);
        add(0,1,1,299,0,0,0, 0,15,5,0,299,0,0);
        add(0,1,1,300,0,0,0, 0,15,6,0,300,1,1);
        add(0,1,0,0,0,0,0, 0,15,6,0,300,0,1);
        add(0,1,1,495,0,0,0, 0,15,7,0,495,0,1);
        add(0,1,0,0,0,0,0, 0,15,7,0,495,0,1);
        add(0,1,0,0,0,0,1, 0,15,7,0,495,0,0);
        add(0,1,0,0,0,0,1, 0,15,7,0,495,0,0);
        add(0,1,1,300,0,0,0, 0,15,8,1,495,1,1);
        add(0,1,0,0,0,0,1, 0,15,8,1,495,0,1);
        add(0,1,0,0,0,0,0, 0,15,8,1,495,0,1);
        add(0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
        add(0,1,1,100,0,0,0, 0,0,1,0,100,0,0);
        add(0,1,1,200,0,0,0, 0,0,2,0,200,0,0);
        add(0,1,1,310,0,0,0, 0,0,3,0,310,1,1);
        add(0,1,1,50,0,0,0, 0,0,4,0,310,0,1);
        add(0,0,1,400,1,0,1, 0,0,0,0,0,0,0);
        add(0,1,0,0,0,0,0, 0,0,0,0,0,0,0);
        add(0,1,1,350,0,0,0, 0,0,1,0,350,1,1);
        add(0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
        add(0,1,1,20,0,0,0, 0,0,1,0,20,0,0);
        add(1,1,1,400,1,0,0, 0,0,0,0,0,0,0);
        add(0,1,0,0,1,0,0, 1,0,0,0,0,0,0);

        foreach (tbl[k]) begin
            drive(tbl[k].rst, tbl[k].sw, tbl[k].en, tbl[k].liv, tbl[k].rq, tbl[k].idx, tbl[k].ack);
            chk("rd_valid", k, int'(rd_valid), tbl[k].v);
            chk("rd_data",  k, int'(rd_data),  tbl[k].d);
            chk("count",    k, int'(count),    tbl[k].c);
            chk("full",     k, int'(full),     tbl[k].f);
            chk("peak",     k, int'(peak),     tbl[k].p);
            chk("clear",    k, int'(clear),    tbl[k].cl);
            chk("alarm",    k, int'(alarm),    tbl[k].al);
        end

        // Back-to-back reads over a freshly filled buffer, newest first
        drive(1,0,0,0,0,0,0);
        for (int i = 0; i < 8; i++) drive(0,1,1,100+i,0,0,0);
        chk("fill_count", 1000, int'(count), 8);
        for (int i = 0; i < 8; i++) begin
            drive(0,1,0,0,1,i,0);
            chk("b2b_valid", 1100+i, int'(rd_valid), 1);
            chk("b2b_data",  1100+i, int'(rd_data), 107-i);
        end
        drive(0,1,0,0,0,0,0);
        chk("b2b_idle_valid", 1200, int'(rd_valid), 0);
        chk("b2b_hold_data",  1200, int'(rd_data), 100);

        // Write with a simultaneous read of the oldest slot when full: read sees pre-write contents
        drive(0,1,1,250,1,7,0);
        chk("wrap_rw_data",  1300, int'(rd_data), 100);
        chk("wrap_rw_count", 1300, int'(count), 8);
        drive(0,1,0,0,1,7,0);
        chk("wrap_oldest",   1301, int'(rd_data), 101);
        drive(0,1,0,0,1,0,0);
        chk("wrap_newest",   1302, int'(rd_data), 250);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
